// File: rtl/approx_adder_error_monitor.sv
// rtl/approx_adder_error_monitor.sv - error statistics checker for an approximate WIDTH-bit adder
//
// Purpose: takes {in1, in2, approx} samples, forms the exact sum and |exact-approx|,
// and accumulates run statistics: sample count, error count, saturating sum of |err|,
// max |err| and the operands of the first sample reaching that max.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_samples       begin a run of num_samples samples (accepted in IDLE/DONE only)
//   in_valid, in_ready       sample handshake, transfer when both high
//   in1, in2, approx         operands and approximate sum under test
//   busy, done               run in progress (RUN/DRAIN) / stats final (DONE)
//   sample_cnt, err_cnt      samples folded into stats / samples with nonzero error
//   sum_abs_err, sat         saturating sum of |err| / sticky saturation flag
//   max_abs_err              largest |err| of the run
//   wce_in1, wce_in2         operands of the first sample that reached max_abs_err
module approx_adder_error_monitor #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 2*WIDTH+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH:0]   approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic             sat,
    output logic [WIDTH:0]   max_abs_err,
    output logic [WIDTH-1:0] wce_in1,
    output logic [WIDTH-1:0] wce_in2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t state, state_nxt;

    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] acc_cnt;
    logic             xfer;
    logic             start_take;

    // Stage 1: exact sum and the sample as received
    logic             s1_valid;
    logic [WIDTH:0]   s1_exact;
    logic [WIDTH:0]   s1_approx;
    logic [WIDTH-1:0] s1_in1;
    logic [WIDTH-1:0] s1_in2;

    // Stage 2: absolute error, folded into the stats on the following edge
    logic             s2_valid;
    logic [WIDTH:0]   s2_abs_err;
    logic [WIDTH-1:0] s2_in1;
    logic [WIDTH-1:0] s2_in2;

    logic [WIDTH:0]   abs_err;
    logic [ACC_W:0]   sum_ext;

    assign xfer       = in_valid & in_ready;
    assign start_take = start & ((state == IDLE) | (state == DONE));

    // Ordered subtraction keeps |err| within WIDTH+1 bits with no wrap.
    assign abs_err = (s1_exact >= s1_approx) ? (s1_exact - s1_approx)
                                             : (s1_approx - s1_exact);

    // One extra bit so a carry out marks saturation.
    assign sum_ext = {1'b0, sum_abs_err} + {{(ACC_W-WIDTH){1'b0}}, s2_abs_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Leave RUN on the transfer that completes the quota, so in_ready
                // is already low in the cycle that would exceed it.
                if (xfer && ((acc_cnt + CNT_ONE) == num_lat)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid && !s2_valid) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            RUN:     begin in_ready = 1'b1; busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_lat    <= '0;
            acc_cnt    <= '0;
            s1_valid   <= 1'b0;
            s1_exact   <= '0;
            s1_approx  <= '0;
            s1_in1     <= '0;
            s1_in2     <= '0;
            s2_valid   <= 1'b0;
            s2_abs_err <= '0;
            s2_in1     <= '0;
            s2_in2     <= '0;
        end else begin
            if (start_take) begin
                num_lat <= num_samples;
                acc_cnt <= '0;
            end else if (xfer) begin
                acc_cnt <= acc_cnt + CNT_ONE;
            end

            s1_valid <= xfer;
            if (xfer) begin
                s1_exact  <= {1'b0, in1} + {1'b0, in2};
                s1_approx <= approx;
                s1_in1    <= in1;
                s1_in2    <= in2;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_abs_err <= abs_err;
                s2_in1     <= s1_in1;
                s2_in2     <= s1_in2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_take) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sat         <= 1'b0;
            max_abs_err <= '0;
            wce_in1     <= '0;
            wce_in2     <= '0;
        end else if (s2_valid) begin
            sample_cnt <= sample_cnt + CNT_ONE;
            if (s2_abs_err != '0) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
            if (sum_ext[ACC_W]) begin
                sum_abs_err <= ACC_MAX;
                sat         <= 1'b1;
            end else begin
                sum_abs_err <= sum_ext[ACC_W-1:0];
            end
            // Strict compare: ties keep the earlier sample, zero error never updates.
            if (s2_abs_err > max_abs_err) begin
                max_abs_err <= s2_abs_err;
                wce_in1     <= s2_in1;
                wce_in2     <= s2_in2;
            end
        end
    end

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// tb/tb_approx_adder_error_monitor.sv - directed self-checking bench for approx_adder_error_monitor
module tb_approx_adder_error_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] num_samples;
    logic        in_valid;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [8:0]  approx;

    logic        in_ready, busy, done, sat;
    logic [16:0] sample_cnt, err_cnt;
    logic [31:0] sum_abs_err;
    logic [8:0]  max_abs_err;
    logic [7:0]  wce_in1, wce_in2;

    logic        b_in_ready, b_busy, b_done, b_sat;
    logic [16:0] b_sample_cnt, b_err_cnt;
    logic [9:0]  b_sum_abs_err;
    logic [8:0]  b_max_abs_err;
    logic [7:0]  b_wce_in1, b_wce_in2;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    approx_adder_error_monitor #(.WIDTH(8), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2), .approx(approx),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .sum_abs_err(sum_abs_err), .sat(sat), .max_abs_err(max_abs_err),
        .wce_in1(wce_in1), .wce_in2(wce_in2)
    );

    approx_adder_error_monitor #(.WIDTH(8), .ACC_W(10)) dut_small (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(b_in_ready), .in1(in1), .in2(in2), .approx(approx),
        .busy(b_busy), .done(b_done), .sample_cnt(b_sample_cnt), .err_cnt(b_err_cnt),
        .sum_abs_err(b_sum_abs_err), .sat(b_sat), .max_abs_err(b_max_abs_err),
        .wce_in1(b_wce_in1), .wce_in2(b_wce_in2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [16:0] n);
        num_samples = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
        int k;
        in1 = a; in2 = b; approx = s; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, done, 1);
    endtask

    task automatic chk_stats(input string tag, input logic [16:0] sc, input logic [16:0] ec,
                             input logic [31:0] sum, input logic [8:0] mx,
                             input logic [7:0] w1, input logic [7:0] w2);
        chk({tag, "_sample_cnt"}, sample_cnt, sc);
        chk({tag, "_err_cnt"}, err_cnt, ec);
        chk({tag, "_sum"}, sum_abs_err, sum);
        chk({tag, "_max"}, max_abs_err, mx);
        chk({tag, "_wce1"}, wce_in1, w1);
        chk({tag, "_wce2"}, wce_in2, w2);
    endtask

    initial begin
        int n_xfer, last_xfer, done_cyc, ready_late, overlap;

        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        in1 = '0; in2 = '0; approx = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat, 0);
        chk_stats("rst", 0, 0, 0, 0, 0, 0);

        // 1: exact samples only
        do_start(4);
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 1);
        send(3, 5, 8);
        send(0, 0, 0);
        send(255, 255, 510);
        send(1, 2, 3);
        wait_done("t1_done");
        chk("t1_busy_off", busy, 0);
        chk_stats("t1", 4, 0, 0, 0, 0, 0);

        // 2: errors, max at 510 from (255,255)
        do_start(3);
        send(255, 255, 0);
        send(1, 1, 3);
        send(7, 0, 7);
        wait_done("t2_done");
        chk_stats("t2", 3, 2, 511, 510, 255, 255);
        chk("t2_sat", sat, 0);
        chk("t2_small_sum", b_sum_abs_err, 511);
        chk("t2_small_sat", b_sat, 0);

        // 3: tie on max, first occurrence kept; stats cleared by start
        do_start(2);
        send(4, 4, 0);
        send(8, 0, 0);
        wait_done("t3_done");
        chk_stats("t3", 2, 2, 16, 8, 4, 4);

        // 4: in_valid held 5 cycles against num=2
        do_start(2);
        in1 = 10; in2 = 20; approx = 30;
        n_xfer = 0; last_xfer = 0; done_cyc = 0; ready_late = 0; overlap = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 5);
            if (in_ready && n_xfer >= 2) ready_late++;
            if (in_valid && in_ready) begin
                n_xfer++;
                last_xfer = cyc + 1;
            end
            if (done && done_cyc == 0) begin
                done_cyc = cyc;
                chk("t4_cnt_at_done", sample_cnt, 2);
            end
            if (done && busy) overlap++;
            @(negedge clk);
        end
        chk("t4_xfers", n_xfer, 2);
        chk("t4_ready_late", ready_late, 0);
        chk("t4_done_latency", done_cyc - last_xfer, 3);
        chk("t4_overlap", overlap, 0);
        chk("t4_in_ready", in_ready, 0);
        chk_stats("t4", 2, 0, 0, 0, 0, 0);

        // 5: saturation on the ACC_W=10 instance
        do_start(3);
        send(255, 255, 0);
        send(255, 255, 0);
        send(255, 255, 0);
        wait_done("t5_done");
        chk("t5_small_sum", b_sum_abs_err, 1023);
        chk("t5_small_sat", b_sat, 1);
        chk("t5_small_err", b_err_cnt, 3);
        chk("t5_wide_sum", sum_abs_err, 1530);
        chk("t5_wide_sat", sat, 0);

        // 6: reset mid-run with samples in flight, then zero-length run
        do_start(5);
        send(9, 9, 0);
        send(1, 1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_sat", sat, 0);
        chk_stats("t6", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_flushed", sample_cnt, 0);
        do_start(0);
        chk("t6_zero_done", done, 1);
        chk("t6_zero_busy", busy, 0);
        in1 = 50; in2 = 50; approx = 0; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("t6_ignored_ready", in_ready, 0);
        chk_stats("t6z", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
